// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared types and constants for the instruction-memory loader.
//   - loader_state_e   : loader FSM states
//   - BYTES_PER_WORD   : bytes packed into one instruction word
//   - WORD_BYTES_SHIFT : log2(BYTES_PER_WORD), word index -> byte address shift
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int BYTES_PER_WORD   = 4;
  localparam int WORD_BYTES_SHIFT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } loader_state_e;

endpackage : cpu_pkg

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
//   Assembles a big-endian 32-bit word from a byte stream: the first byte of a
//   word ends up in [31:24], the fourth in [7:0].
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clear      in   drop any partial word and restart at byte 0
//   shift_en   in   byte_in is consumed this cycle
//   byte_in    in   8-bit data byte
//   word_nxt   out  word as it will look once byte_in is shifted in; it is the
//                   complete word in the cycle word_full is high
//   word_full  out  this cycle's byte completes a word
// -----------------------------------------------------------------------------
module byte_packer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_nxt,
  output logic        word_full
);

  // Only the three most recent bytes need storage; the fourth arrives on
  // byte_in in the completing cycle.
  logic [23:0] word_q;
  logic [1:0]  cnt_q;

  assign word_nxt  = {word_q, byte_in};
  assign word_full = shift_en && (cnt_q == 2'(BYTES_PER_WORD - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (shift_en) begin
      word_q <= word_nxt[23:0];
      // Two-bit counter wraps to 0 after the fourth byte.
      cnt_q  <= cnt_q + 2'd1;
    end
  end

endmodule : byte_packer

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//   Streams a program from a host byte source into the instruction memory and
//   holds the CPU in reset until the whole program has been written.
//
// Ports
//   clk_i         in   clock, rising edge
//   rst_i         in   asynchronous active-low reset
//   start_i       in   1-cycle pulse: begin loading len_i words
//   abort_i       in   abandon a load in progress
//   len_i         in   word count, sampled on an accepted start_i
//   byte_data_i   in   program byte
//   byte_valid_i  in   byte_data_i valid
//   byte_ready_o  out  loader accepts a byte this cycle
//   mem_we_o      out  IM write strobe, one cycle per word
//   mem_addr_o    out  IM byte address (word aligned)
//   mem_data_o    out  IM write data
//   cpu_rst_o     out  CPU reset, active-low (0 = CPU held)
//   busy_o        out  load in progress
//   done_o        out  load complete (level)
//   err_o         out  requested length exceeds memory depth (level)
// -----------------------------------------------------------------------------
module instr_mem_loader
  import cpu_pkg::*;
#(
  parameter int MEM_WORDS  = 128,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic [7:0]            byte_data_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [31:0]           mem_data_o,
  output logic                  cpu_rst_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int                LEN_W   = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MEM_WORDS);

  loader_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]   word_idx_q;
  logic [LEN_W-1:0]        len_q;
  logic [31:0]             addr_q;
  logic [31:0]             data_q;

  logic                    recv_ready;
  logic                    accept;
  logic                    load_go;
  logic                    abort_go;
  logic                    last_word;
  logic [31:0]             pack_word;
  logic                    pack_full;

  // Ready is deliberately kept out of the FSM process: the packer's word_full
  // depends on it and feeds back into next-state logic.
  assign recv_ready   = (state_q == ST_RECV) && !abort_i;
  assign accept       = recv_ready && byte_valid_i;
  assign byte_ready_o = recv_ready;

  // len_q >= 1 whenever this is used, so the subtraction cannot underflow.
  assign last_word = ({1'b0, word_idx_q} == (len_q - LEN_W'(1)));

  byte_packer u_packer (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .clear     (load_go || abort_go),
    .shift_en  (accept),
    .byte_in   (byte_data_i),
    .word_nxt  (pack_word),
    .word_full (pack_full)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    mem_we_o  = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    err_o     = 1'b0;
    cpu_rst_o = 1'b0;
    load_go   = 1'b0;
    abort_go  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        done_o    = (state_q == ST_DONE);
        cpu_rst_o = (state_q == ST_DONE);
        err_o     = (state_q == ST_ERR);
        // abort_i outranks start_i; on its own it is a no-op here.
        if (start_i && !abort_i) begin
          if (len_i == '0) begin
            state_d = ST_DONE;
          end else if (len_i > MAX_LEN) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_RECV;
            load_go = 1'b1;
          end
        end
      end

      ST_RECV: begin
        busy_o = 1'b1;
        if (abort_i) begin
          state_d  = ST_IDLE;
          abort_go = 1'b1;
        end else if (pack_full) begin
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        busy_o = 1'b1;
        // An abort landing on the write cycle suppresses the strobe so the
        // abandoned load leaves nothing behind in memory.
        if (abort_i) begin
          state_d  = ST_IDLE;
          abort_go = 1'b1;
        end else begin
          mem_we_o = 1'b1;
          state_d  = last_word ? ST_DONE : ST_RECV;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;

      if (load_go) begin
        word_idx_q <= '0;
        len_q      <= len_i;
      end else if (mem_we_o && !last_word) begin
        // Stop at the final word so a full-depth load never wraps the index.
        word_idx_q <= word_idx_q + 1'b1;
      end

      // Capture address and data as the word completes; they then hold
      // through the write cycle and until the next word is ready.
      if (pack_full) begin
        data_q <= pack_word;
        addr_q <= 32'(word_idx_q) << WORD_BYTES_SHIFT;
      end
    end
  end

  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;

endmodule : instr_mem_loader
